foobar_event_fifo: RTL and testbench

- Downstream consumer of the foobar counter stage.
- Samples foo/bar/count every clock and captures one event entry whenever foo or bar is asserted while enabled.
- Buffers entries in a small first-word-fall-through FIFO and presents them on a valid/ready output interface, for a logger or UART stage.
- Counts events dropped on overflow.

---
 rtl/foobar_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/foobar_event_fifo.sv | 82 ++++++++
 tb/tb_foobar_event_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/foobar_pkg.sv
// Shared types for the foobar logging path.
//   kind_t  : event classification, bit 1 = foo, bit 0 = bar
//   event_t : one captured event at the default count width
//   CNT_W   : default width of the foobar count field
package foobar_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_BAR    = 2'b01,
    KIND_FOO    = 2'b10,
    KIND_FOOBAR = 2'b11
  } kind_t;

  typedef struct packed {
    kind_t            kind;
    logic [CNT_W-1:0] count;
  } event_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   push, wdata   : write request and data; accepted when not full, or
//                   when full and an effective pop frees a slot that edge
//   pop           : read request; ignored while empty
//   rdata         : head entry (mem[rd_ptr]), valid whenever !empty
//   level         : occupancy 0..DEPTH (registered)
//   full, empty   : registered flags derived from the level counter
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) level_next = level + LW'(1);
    else if (do_pop && !do_push) level_next = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // the read side is qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/foobar_event_fifo.sv
// Captures foo/bar events from the foobar counter stage and buffers them
// for a downstream logger.
// Ports:
//   clk, rst             : clock, synchronous active-low reset
//   en, foo, bar, count  : foobar stage outputs; an event is captured when
//                          en & (foo | bar) at a rising edge
//   out_valid/out_ready  : output handshake (see below)
//   out_kind, out_count  : head entry, forced to 0 while empty
//   level, full, empty   : occupancy status
//   drop_count           : saturating count of events lost to overflow
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never drops and out_kind/out_count never
// change while out_valid = 1 and out_ready = 0. out_ready is ignored while
// out_valid = 0.
module foobar_event_fifo #(
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   foo,
  input  logic                   bar,
  input  logic [CNT_W-1:0]       count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [CNT_W-1:0]       out_count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [DROP_W-1:0]      drop_count
);

  import foobar_pkg::*;

  localparam int W = 2 + CNT_W;

  kind_t          cap_kind;
  logic           push_req;
  logic           pop;
  logic           drop;
  logic [W-1:0]   wdata;
  logic [W-1:0]   rdata;

  assign cap_kind = kind_t'({foo, bar});
  assign push_req = en & (foo | bar);
  assign pop      = out_valid & out_ready;
  // Lost only when there is no room now and no slot freed this edge.
  assign drop     = push_req & full & ~pop;
  assign wdata    = {cap_kind, count};

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_kind  = empty ? 2'b00 : rdata[W-1 -: 2];
  assign out_count = empty ? '0 : rdata[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_foobar_event_fifo.sv
module tb_foobar_event_fifo;

  logic       clk;
  logic       rst;
  logic       en;
  logic       foo;
  logic       bar;
  logic [7:0] count;
  logic       out_ready;

  logic       out_valid;
  logic [1:0] out_kind;
  logic [7:0] out_count;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic [7:0] drop_count;

  logic       d2_out_valid;
  logic [1:0] d2_out_kind;
  logic [7:0] d2_out_count;
  logic [3:0] d2_level;
  logic       d2_full;
  logic       d2_empty;
  logic [1:0] d2_drop_count;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  foobar_event_fifo #(.CNT_W(8), .DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_count(out_count), .level(level), .full(full), .empty(empty),
    .drop_count(drop_count)
  );

  // Same stimulus, narrow drop counter to exercise saturation.
  foobar_event_fifo #(.CNT_W(8), .DEPTH(8), .DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar), .count(count),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_kind(d2_out_kind),
    .out_count(d2_out_count), .level(d2_level), .full(d2_full),
    .empty(d2_empty), .drop_count(d2_drop_count)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; foo = 1'b0; bar = 1'b0; count = 8'd0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; foo = 1'b1; bar = 1'b0; count = 8'd5; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
          drop_count !== 8'd0 || out_count !== 8'd0 || out_kind !== 2'b00) begin
        failures++;
        $display("FAIL reset cyc=%0d got valid=%b level=%0d empty=%b full=%b drop=%0d cnt=%0d kind=%b exp 0/0/1/0/0/0/00",
                 c, out_valid, level, empty, full, drop_count, out_count, out_kind);
      end
    end
    foo = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    foo = 1'b1; count = 8'd3;
    step();
    foo = 1'b0; count = 8'd0;
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 2'b10 || out_count !== 8'd3 || level !== 4'd1) begin
      failures++;
      $display("FAIL single_push got valid=%b kind=%b cnt=%0d level=%0d exp 1/10/3/1",
               out_valid, out_kind, out_count, level);
    end
    // Hold: head must stay put while not accepted.
    step();
    checks++;
    if (out_valid !== 1'b1 || out_count !== 8'd3 || level !== 4'd1) begin
      failures++;
      $display("FAIL single_hold got valid=%b cnt=%0d level=%0d exp 1/3/1", out_valid, out_count, level);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (level !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
      failures++;
      $display("FAIL single_pop got level=%0d empty=%b valid=%b cnt=%0d exp 0/1/0/0",
               level, empty, out_valid, out_count);
    end
    // out_ready while empty has no effect.
    step();
    checks++;
    if (level !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL ready_while_empty got level=%0d empty=%b exp 0/1", level, empty);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      foo = 1'b1; count = 8'(i);
      step();
      if (i == 7 || i == 8) begin
        checks++;
        if (full !== (i == 8)) begin
          failures++;
          $display("FAIL overflow_full after=%0d got=%b exp=%b", i, full, (i == 8));
        end
      end
    end
    foo = 1'b0;
    checks++;
    if (drop_count !== 8'd2 || level !== 4'd8 || full !== 1'b1 || d2_drop_count !== 2'd2) begin
      failures++;
      $display("FAIL overflow_drop got drop=%0d d2drop=%0d level=%0d full=%b exp 2/2/8/1",
               drop_count, d2_drop_count, level, full);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_count !== 8'(i) || out_kind !== 2'b10) begin
        failures++;
        $display("FAIL drain_order idx=%0d got valid=%b cnt=%0d kind=%b exp 1/%0d/10",
                 i, out_valid, out_count, out_kind, i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || level !== 4'd0 || drop_count !== 8'd2) begin
      failures++;
      $display("FAIL drain_empty got empty=%b level=%0d drop=%0d exp 1/0/2", empty, level, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 8; i++) begin
      foo = 1'b1; count = 8'(i);
      exp_q.push_back(8'(i));
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_count !== exp_q[0]) begin
        failures++;
        $display("FAIL stream_head k=%0d got valid=%b cnt=%0d exp 1/%0d", k, out_valid, out_count, exp_q[0]);
      end
      foo = 1'b1; count = 8'(9 + k);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(8'(9 + k));
      checks++;
      if (level !== 4'd8 || full !== 1'b1 || drop_count !== 8'd0) begin
        failures++;
        $display("FAIL stream_level k=%0d got level=%0d full=%b drop=%0d exp 8/1/0", k, level, full, drop_count);
      end
    end
    foo = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_count !== 8'd21) begin
      failures++;
      $display("FAIL stream_final_head got=%0d exp=21", out_count);
    end
  endtask

  task automatic test_foobar_en();
    do_reset();
    foo = 1'b1; bar = 1'b1; count = 8'd15;
    step();
    en = 1'b0; bar = 1'b0; count = 8'd99;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (level !== 4'd1 || out_kind !== 2'b11 || out_count !== 8'd15 || drop_count !== 8'd0) begin
        failures++;
        $display("FAIL en_block cyc=%0d got level=%0d kind=%b cnt=%0d drop=%0d exp 1/11/15/0",
                 c, level, out_kind, out_count, drop_count);
      end
    end
    // Draining continues with en low.
    out_ready = 1'b1;
    step();
    checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      failures++;
      $display("FAIL en_drain got empty=%b level=%0d exp 1/0", empty, level);
    end
    out_ready = 1'b0; foo = 1'b0; en = 1'b1;
    // Bar-only event kind.
    bar = 1'b1; count = 8'd7;
    step();
    bar = 1'b0;
    checks++;
    if (out_kind !== 2'b01 || out_count !== 8'd7) begin
      failures++;
      $display("FAIL bar_kind got kind=%b cnt=%0d exp 01/7", out_kind, out_count);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      foo = 1'b1; count = 8'(i);
      step();
    end
    for (int k = 1; k <= 6; k++) begin
      foo = 1'b1; count = 8'(100 + k);
      step();
      checks++;
      if (d2_drop_count !== 2'((k > 3) ? 3 : k) || drop_count !== 8'(k)) begin
        failures++;
        $display("FAIL drop_sat k=%0d got d2=%0d wide=%0d exp %0d/%0d",
                 k, d2_drop_count, drop_count, (k > 3) ? 3 : k, k);
      end
    end
    foo = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    checks++;
    if (level !== 4'd5 || d2_level !== 4'd5 || out_count !== 8'd4) begin
      failures++;
      $display("FAIL pre_reset got level=%0d d2level=%0d cnt=%0d exp 5/5/4", level, d2_level, out_count);
    end
    rst = 1'b0; foo = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b1; foo = 1'b0; out_ready = 1'b0;
    checks++;
    if (level !== 4'd0 || out_valid !== 1'b0 || drop_count !== 8'd0 ||
        d2_drop_count !== 2'd0 || d2_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got level=%0d valid=%b drop=%0d d2drop=%0d d2valid=%b exp 0/0/0/0/0",
               level, out_valid, drop_count, d2_drop_count, d2_out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0; foo = 1'b0; bar = 1'b0; count = 8'd0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_foobar_en();
    test_drop_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
